qpp_addr_gen: RTL

//  Read-side address generator for the turbo-code interleaver. The write side fills the

---
 rtl/ilv_pkg.sv | 39 +++
 rtl/qpp_addr_gen_mod_add.sv | 22 ++
 rtl/qpp_addr_gen.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ilv_pkg.sv
// Shared interleaver constants, QPP coefficients and FSM state type.
// Used by the read-side QPP address generator and the write-side index generator.
package ilv_pkg;

  localparam int unsigned AW      = 14;
  localparam int unsigned K_SMALL = 1056;
  localparam int unsigned K_LARGE = 6144;

  localparam int unsigned F1_SMALL = 17;
  localparam int unsigned F2_SMALL = 66;
  localparam int unsigned F1_LARGE = 263;
  localparam int unsigned F2_LARGE = 480;

  // g(0) = (f1 + f2) mod K, d = (2 * f2) mod K
  localparam int unsigned G0_SMALL = (F1_SMALL + F2_SMALL) % K_SMALL;
  localparam int unsigned D_SMALL  = (2 * F2_SMALL) % K_SMALL;
  localparam int unsigned G0_LARGE = (F1_LARGE + F2_LARGE) % K_LARGE;
  localparam int unsigned D_LARGE  = (2 * F2_LARGE) % K_LARGE;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE1 = 2'd2,
    DONE2 = 2'd3
  } state_e;

  function automatic logic [AW-1:0] k_of(input logic sel);
    return sel ? AW'(K_LARGE) : AW'(K_SMALL);
  endfunction

  function automatic logic [AW-1:0] g0_of(input logic sel);
    return sel ? AW'(G0_LARGE) : AW'(G0_SMALL);
  endfunction

  function automatic logic [AW-1:0] d_of(input logic sel);
    return sel ? AW'(D_LARGE) : AW'(D_SMALL);
  endfunction

endpackage

// File: rtl/qpp_addr_gen_mod_add.sv
// Combinational (a + b) mod K for operands already below K: one conditional subtract.
module mod_add
  import ilv_pkg::*;
(
  input  logic [AW-1:0] a_i,
  input  logic [AW-1:0] b_i,
  input  logic [AW-1:0] kmod_i,
  output logic [AW-1:0] sum_o
);

  logic [AW:0] sum_c;
  logic [AW:0] wrap_c;

  assign sum_c  = {1'b0, a_i} + {1'b0, b_i};
  assign wrap_c = sum_c - {1'b0, kmod_i};

  always_comb begin
    sum_o = sum_c[AW-1:0];
    if (sum_c >= {1'b0, kmod_i}) sum_o = wrap_c[AW-1:0];
  end

endmodule

// File: rtl/qpp_addr_gen.sv
// QPP interleaver read-address generator: emits pi(i) = (f1*i + f2*i^2) mod K, i = 0..K-1,
// using the second-order difference recursion (adders only), with valid/ready handshake.
module qpp_addr_gen
  import ilv_pkg::*;
(
  input  logic          clock,
  input  logic          reset,
  input  logic          k,
  input  logic          start,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [AW-1:0] addr,
  output logic [AW-1:0] idx,
  output logic          last,
  output logic          busy,
  output logic          done
);

  state_e        state_q;
  logic          kreg_q;
  logic [AW-1:0] pi_q;
  logic [AW-1:0] g_q;
  logic [AW-1:0] idx_q;
  logic          out_valid_q;
  logic          last_q;
  logic          busy_q;
  logic          done_q;

  logic [AW-1:0] kmod_c;
  logic [AW-1:0] kmax_c;
  logic [AW-1:0] d_c;
  logic [AW-1:0] pi_d;
  logic [AW-1:0] g_d;
  logic [AW-1:0] idx_d;
  logic          xfer_c;

  assign kmod_c = k_of(kreg_q);
  assign kmax_c = kmod_c - AW'(1);
  assign d_c    = d_of(kreg_q);
  assign idx_d  = idx_q + AW'(1);
  assign xfer_c = out_valid_q & out_ready;

  // pi(i+1) = pi(i) + g(i), g(i+1) = g(i) + d, both mod K
  mod_add u_pi_add (
    .a_i    (pi_q),
    .b_i    (g_q),
    .kmod_i (kmod_c),
    .sum_o  (pi_d)
  );

  mod_add u_g_add (
    .a_i    (g_q),
    .b_i    (d_c),
    .kmod_i (kmod_c),
    .sum_o  (g_d)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      kreg_q      <= 1'b0;
      pi_q        <= '0;
      g_q         <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      last_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            kreg_q      <= k;
            pi_q        <= '0;
            g_q         <= g0_of(k);
            idx_q       <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          // Without a transfer every output holds; valid is never withdrawn.
          if (xfer_c) begin
            if (idx_q == kmax_c) begin
              out_valid_q <= 1'b0;
              last_q      <= 1'b0;
              done_q      <= 1'b1;
              state_q     <= DONE1;
            end else begin
              idx_q  <= idx_d;
              pi_q   <= pi_d;
              g_q    <= g_d;
              last_q <= (idx_d == kmax_c);
            end
          end
        end
        DONE1: begin
          done_q  <= 1'b0;
          state_q <= DONE2;
        end
        DONE2: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          out_valid_q <= 1'b0;
          last_q      <= 1'b0;
          busy_q      <= 1'b0;
          done_q      <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign out_valid = out_valid_q;
  assign addr      = pi_q;
  assign idx       = idx_q;
  assign last      = last_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
